// File: rtl/lut_func_pkg.sv
// Shared types and constants for the programmable truth-table function unit.
package lut_func_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SWEEP = 2'd2
  } state_t;

  // Minterms 0,2,4,6,7: the classic 3-input textbook primitive.
  localparam logic [7:0] MASK_02467 = 8'hD5;
  // 3-input majority, handy as a bench reload value.
  localparam logic [7:0] MASK_MAJ   = 8'hE8;

  function automatic int tbl_size(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// Serial mask loader: collects bits into a shadow register and swaps the
// whole table into the live mask in one edge, so evaluation never sees a partial mask.
module lut_cfg_shifter
  import lut_func_pkg::*;
#(
  parameter int                     N_IN      = 3,
  parameter logic [(1<<N_IN)-1:0]   INIT_MASK = (1<<N_IN)'(MASK_02467)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       active,
  input  logic                       cfg_valid,
  input  logic                       cfg_bit,
  input  logic                       cfg_abort,
  output logic                       commit,
  output logic [(1<<N_IN)-1:0]       mask,
  output logic                       cfg_done
);

  localparam int              TBL  = tbl_size(N_IN);
  localparam logic [N_IN:0]   LAST = (N_IN+1)'(TBL - 1);

  logic [TBL-1:0] shadow, shadow_nxt;
  logic [N_IN:0]  count;
  logic           take;

  assign take   = active && cfg_valid && !cfg_abort;
  assign commit = take && (count == LAST);

  // Final bit is merged combinationally so the commit edge loads the full table.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[count[N_IN-1:0]] = cfg_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow   <= '0;
      count    <= '0;
      mask     <= INIT_MASK;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= commit;
      if (start || (active && cfg_abort) || commit) begin
        shadow <= '0;
        count  <= '0;
      end else if (take) begin
        shadow <= shadow_nxt;
        count  <= count + (N_IN+1)'(1);
      end
      if (commit)
        mask <= shadow_nxt;
    end
  end

endmodule

// File: rtl/lut_func_engine.sv
// Registered N-input truth-table function unit with valid/ready evaluate path,
// serial mask reload and a self-test sweep that streams (index, f) pairs.
module lut_func_engine
  import lut_func_pkg::*;
#(
  parameter int                     N_IN      = 3,
  parameter logic [(1<<N_IN)-1:0]   INIT_MASK = (1<<N_IN)'(MASK_02467)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_f,
  output logic [N_IN-1:0] out_idx,
  input  logic            out_ready,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_done,
  input  logic            sweep_start,
  output logic            sweep_done
);

  localparam int TBL = tbl_size(N_IN);

  state_t          state, state_nxt;
  logic [TBL-1:0]  mask;
  logic [N_IN:0]   sweep_cnt;
  logic            slot_free, start_cfg, start_sweep;
  logic            eval_take, sweep_emit, commit;

  assign slot_free   = !out_valid || out_ready;
  assign start_cfg   = (state == IDLE) && cfg_start;
  assign start_sweep = (state == IDLE) && !cfg_start && sweep_start;
  // Ready already folds in start priority, so in_valid & in_ready means accepted.
  assign in_ready    = (state == IDLE) && slot_free && !cfg_start && !sweep_start;
  assign eval_take   = in_valid && in_ready;
  // The MSB of the counter marks "all entries issued"; only the drain remains.
  assign sweep_emit  = (state == SWEEP) && slot_free && !sweep_cnt[N_IN];
  assign sweep_done  = (state == SWEEP) && sweep_cnt[N_IN] && out_valid && out_ready;

  lut_cfg_shifter #(
    .N_IN      (N_IN),
    .INIT_MASK (INIT_MASK)
  ) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .start     (start_cfg),
    .active    (state == LOAD),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .commit    (commit),
    .mask      (mask),
    .cfg_done  (cfg_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_cfg)        state_nxt = LOAD;
        else if (start_sweep) state_nxt = SWEEP;
      end
      LOAD:    if (cfg_abort || commit) state_nxt = IDLE;
      SWEEP:   if (sweep_done)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sweep_cnt <= '0;
    else if (start_sweep)
      sweep_cnt <= '0;
    else if (sweep_emit)
      sweep_cnt <= sweep_cnt + (N_IN+1)'(1);
  end

  // Output slot: holds until consumed; a refill in the same cycle as a drain is allowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_f     <= 1'b0;
      out_idx   <= '0;
    end else if (eval_take) begin
      out_valid <= 1'b1;
      out_f     <= mask[in_data];
      out_idx   <= in_data;
    end else if (sweep_emit) begin
      out_valid <= 1'b1;
      out_f     <= mask[sweep_cnt[N_IN-1:0]];
      out_idx   <= sweep_cnt[N_IN-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/lut_func_engine.md
Name: lut_func_engine

Overview:
- Programmable, registered N-input truth-table function unit.
- Generalises the fixed 3-input minterm primitive: width is a parameter, and the minterm mask is reloadable at run time through a serial configuration port.
- Adds a valid/ready evaluate path with backpressure, plus a self-test sweep mode that walks every input combination and streams (index, f) pairs.
- Sits beside the textbook-circuit blocks as the reusable function generator for exercises and benches.

Parameters:
- N_IN, 3, number of function inputs (1..8); table size is 2^N_IN.
- INIT_MASK, 8'hD5, reset minterm mask, bit i = f(i); the default is minterms 0,2,4,6,7. Width is 2^N_IN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  evaluate request.
- in_data  in  N_IN  input vector; in_data[N_IN-1] is the MSB (A), so the minterm index equals in_data.
- in_ready  out  1  evaluate request accepted this cycle.
- out_valid  out  1  result valid.
- out_f  out  1  function value.
- out_idx  out  N_IN  minterm index the result belongs to.
- out_ready  in  1  consumer accepts result.
- cfg_start  in  1  begin mask load (IDLE only).
- cfg_valid  in  1  cfg_bit qualifier.
- cfg_bit  in  1  serial mask bit, minterm 0 first.
- cfg_abort  in  1  abandon load.
- cfg_done  out  1  one-cycle pulse: new mask committed.
- sweep_start  in  1  begin self-test sweep (IDLE only).
- sweep_done  out  1  one-cycle pulse coincident with acceptance of the last sweep result.

Behaviour:
- Reset (async, immediate):
  - State is IDLE and mask = INIT_MASK.
  - Shadow register, bit counter and sweep counter are cleared.
  - out_valid, out_f, out_idx, cfg_done and sweep_done are 0.
  - in_ready is 1 once rst deasserts.
- Output register ("slot free"):
  - out_valid/out_f/out_idx hold their values until out_valid & out_ready.
  - The slot is free when !out_valid | out_ready.
- IDLE state:
  - in_ready = slot free; it is 0 in every other state.
  - Start-request priority when several are asserted in one cycle: cfg_start, then sweep_start, then in_valid. Lower-priority requests that lose are ignored, not queued.
  - in_valid & in_ready: next cycle out_valid=1, out_f=mask[in_data], out_idx=in_data. Latency is 1 cycle, throughput is 1 per cycle with out_ready held high.
- LOAD state:
  - Entered from cfg_start in IDLE; the shadow register and bit counter are cleared on entry.
  - Each cycle with cfg_valid: shadow[count] <= cfg_bit and count increments. Cycles without cfg_valid hold.
  - When the 2^N_IN-th bit is accepted: mask <= completed shadow, cfg_done pulses the following cycle, state returns to IDLE.
  - The mask updates atomically; no evaluation ever sees a partial mask.
  - cfg_abort (priority over cfg_valid): return to IDLE, shadow discarded, mask unchanged, no cfg_done.
  - A pending out_valid result keeps draining normally during LOAD.
- SWEEP state:
  - Entered from sweep_start in IDLE; the counter starts at 0.
  - Each cycle with the slot free: present out_idx=count, out_f=mask[count], out_valid=1, then count increments.
  - When the result with count = 2^N_IN-1 is accepted (out_valid & out_ready): sweep_done pulses in that cycle, state returns to IDLE.
  - out_ready low stalls the counter; no index is skipped or repeated.
  - cfg_start, sweep_start and in_valid are ignored during SWEEP.
- Wrap-around: counters are N_IN+1 bits wide, so the terminal condition is exact for N_IN=8 (256 entries).
- Reset asserted mid-LOAD or mid-SWEEP:
  - Mask returns to INIT_MASK and any partial load is lost.
  - No cfg_done or sweep_done pulse is emitted.

Decomposition:
- Package lut_func_pkg holds:
  - state typedef {IDLE, LOAD, SWEEP};
  - localparam TBL = 1<<N_IN, supplied via function;
  - default mask constant MASK_02467 = 8'hD5;
  - MASK_MAJ = 8'hE8 for benches.
- One sub-module, lut_cfg_shifter: shadow register, bit counter, commit/abort handling; outputs mask and cfg_done.
- Top level: FSM, output register and sweep counter.

Test Plan:
- Reset, out_ready=1, evaluate in_data 0..7 back-to-back -> out_f 1,0,1,0,1,0,1,1 on consecutive cycles, each 1 cycle after acceptance, out_idx matching.
- cfg_start, shift bits 0,0,0,1,0,1,1,1 (mask 0xE8, majority) with cfg_valid gaps -> cfg_done 1 cycle after the 8th bit. Then eval 3 -> 1, eval 4 -> 0, eval 6 -> 1.
- Load 4 bits, assert cfg_abort -> no cfg_done, state IDLE, eval 7 -> 1 and eval 1 -> 0 (still 0xD5).
- sweep_start with out_ready toggling 1,0,0,1,... -> out_idx 0..7 each exactly once, f matching the mask. sweep_done coincides with acceptance of idx 7. in_ready=0 throughout.
- cfg_start, sweep_start and in_valid asserted in the same cycle -> LOAD entered, no sweep started, no evaluation result produced.
- rst pulsed mid-sweep at idx 3 -> all outputs 0 immediately, mask 0xD5, no sweep_done. A new sweep restarts at idx 0.
